// File: rtl/pkt_bus_pkg.sv
// Shared state encoding and register-window offsets for the PKT bus master.
package pkt_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_IDX = 3'd1,
    WR_REQ = 3'd2,
    RD_CHK = 3'd3,
    WR_CLR = 3'd4,
    DONE   = 3'd5
  } pkt_state_e;

  localparam logic [31:0] PKT_OFF_REQ    = 32'h0000_0000;
  localparam logic [31:0] PKT_OFF_KEYIDX = 32'h0000_0004;

endpackage

// File: rtl/pkt_bus_master_if.sv
// Client handshake plus register-bus initiator signals of the PKT bus master.
interface pkt_bus_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                      key_valid_i;
  logic                      key_ready_o;
  logic [31:0]               key_index_i;
  logic                      done_o;
  logic                      err_o;
  logic [ADDR_WIDTH-1:0]     reg_addr_o;
  logic                      reg_write_o;
  logic [DATA_WIDTH-1:0]     reg_wdata_o;
  logic [DATA_WIDTH/8-1:0]   reg_wstrb_o;
  logic                      reg_valid_o;
  logic [DATA_WIDTH-1:0]     reg_rdata_i;
  logic                      reg_ready_i;
  logic                      reg_error_i;

  modport master (
    input  key_valid_i, key_index_i, reg_rdata_i, reg_ready_i, reg_error_i,
    output key_ready_o, done_o, err_o, reg_addr_o, reg_write_o, reg_wdata_o,
           reg_wstrb_o, reg_valid_o
  );

  modport slave (
    output key_valid_i, key_index_i, reg_rdata_i, reg_ready_i, reg_error_i,
    input  key_ready_o, done_o, err_o, reg_addr_o, reg_write_o, reg_wdata_o,
           reg_wstrb_o, reg_valid_o
  );

endinterface

// File: rtl/pkt_bus_timeout.sv
// Per-state wait counter; expired fires in the cycle the count would reach TIMEOUT_CYCLES.
module pkt_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // wait counter: clear has priority over counting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= {CNT_W{1'b0}};
    end else if (clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (count) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = count && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pkt_bus_master.sv
// Issues the PKT key-index / request / clear register sequence for each client key.
// Define PKT_BUS_MASTER_READBACK_EN to add a read-back check of the request bit.
module pkt_bus_master
  import pkt_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = {ADDR_WIDTH{1'b0}},
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pkt_bus_master_if.master       bus
);

  localparam logic [2:0] S_IDLE   = 3'(IDLE);
  localparam logic [2:0] S_WR_IDX = 3'(WR_IDX);
  localparam logic [2:0] S_WR_REQ = 3'(WR_REQ);
  localparam logic [2:0] S_RD_CHK = 3'(RD_CHK);
  localparam logic [2:0] S_WR_CLR = 3'(WR_CLR);
  localparam logic [2:0] S_DONE   = 3'(DONE);

  localparam logic [ADDR_WIDTH-1:0] ADDR_REQ    = BASE_ADDR + ADDR_WIDTH'(PKT_OFF_REQ);
  localparam logic [ADDR_WIDTH-1:0] ADDR_KEYIDX = BASE_ADDR + ADDR_WIDTH'(PKT_OFF_KEYIDX);

  logic [2:0]            r_state;
  logic [31:0]           r_index;
  logic                  r_err;
  logic                  r_key_ready;
  logic                  r_done;
  logic                  r_err_o;
  logic                  r_valid;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [2:0]            w_next_state;
  logic                  w_take;
  logic [31:0]           w_index;
  logic                  w_beat;
  logic                  w_count;
  logic                  w_clear;
  logic                  w_expired;
  logic                  w_rd_bad;
  logic                  w_set_err;
  logic                  w_nx_valid;
  logic                  w_nx_write;
  logic [ADDR_WIDTH-1:0] w_nx_addr;
  logic [DATA_WIDTH-1:0] w_nx_wdata;
  logic                  w_unused_rdata;

  assign w_take         = (r_state == S_IDLE) && bus.key_valid_i && r_key_ready;
  assign w_index        = w_take ? bus.key_index_i : r_index;
  assign w_beat         = r_valid && bus.reg_ready_i;
  assign w_count        = r_valid && !bus.reg_ready_i;
  assign w_clear        = (w_next_state != r_state);
  assign w_set_err      = (w_beat && bus.reg_error_i) || w_expired || w_rd_bad;
  assign w_unused_rdata = ^bus.reg_rdata_i;

  pkt_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (w_clear),
    .count   (w_count),
    .expired (w_expired)
  );

  // next-state decode; a bus error or timeout in any beat short-cuts to DONE
  always_comb begin
    w_next_state = r_state;
    w_rd_bad     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) w_next_state = S_WR_IDX;
        else        w_next_state = S_IDLE;
      end
      S_WR_IDX: begin
        if (w_beat)         w_next_state = bus.reg_error_i ? S_DONE : S_WR_REQ;
        else if (w_expired) w_next_state = S_DONE;
        else                w_next_state = S_WR_IDX;
      end
      S_WR_REQ: begin
`ifdef PKT_BUS_MASTER_READBACK_EN
        if (w_beat)         w_next_state = bus.reg_error_i ? S_DONE : S_RD_CHK;
`else
        if (w_beat)         w_next_state = bus.reg_error_i ? S_DONE : S_WR_CLR;
`endif
        else if (w_expired) w_next_state = S_DONE;
        else                w_next_state = S_WR_REQ;
      end
`ifdef PKT_BUS_MASTER_READBACK_EN
      S_RD_CHK: begin
        if (w_beat) begin
          w_rd_bad     = !bus.reg_rdata_i[0];
          w_next_state = (bus.reg_error_i || !bus.reg_rdata_i[0]) ? S_DONE : S_WR_CLR;
        end else if (w_expired) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RD_CHK;
        end
      end
`endif
      S_WR_CLR: begin
        if (w_beat || w_expired) w_next_state = S_DONE;
        else                     w_next_state = S_WR_CLR;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // bus request for the state being entered, so outputs come straight from flops
  always_comb begin
    w_nx_valid = 1'b0;
    w_nx_write = 1'b0;
    w_nx_addr  = {ADDR_WIDTH{1'b0}};
    w_nx_wdata = {DATA_WIDTH{1'b0}};
    case (w_next_state)
      S_WR_IDX: begin
        w_nx_valid = 1'b1;
        w_nx_write = 1'b1;
        w_nx_addr  = ADDR_KEYIDX;
        w_nx_wdata = DATA_WIDTH'(w_index);
      end
      S_WR_REQ: begin
        w_nx_valid = 1'b1;
        w_nx_write = 1'b1;
        w_nx_addr  = ADDR_REQ;
        w_nx_wdata = DATA_WIDTH'(32'h1);
      end
`ifdef PKT_BUS_MASTER_READBACK_EN
      S_RD_CHK: begin
        w_nx_valid = 1'b1;
        w_nx_addr  = ADDR_REQ;
      end
`endif
      S_WR_CLR: begin
        w_nx_valid = 1'b1;
        w_nx_write = 1'b1;
        w_nx_addr  = ADDR_REQ;
      end
      default: begin
        w_nx_valid = 1'b0;
      end
    endcase
  end

  // FSM state, latched key index and sticky error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_index <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_index <= w_index;
      if (r_state == S_DONE) r_err <= 1'b0;
      else if (w_set_err)    r_err <= 1'b1;
      else                   r_err <= r_err;
    end
  end

  // registered client and bus outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_key_ready <= 1'b1;
      r_done      <= 1'b0;
      r_err_o     <= 1'b0;
      r_valid     <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= {ADDR_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
    end else begin
      r_key_ready <= (w_next_state == S_IDLE);
      r_done      <= (w_next_state == S_DONE);
      r_err_o     <= (w_next_state == S_DONE) && (r_err || w_set_err);
      r_valid     <= w_nx_valid;
      r_write     <= w_nx_write;
      r_addr      <= w_nx_addr;
      r_wdata     <= w_nx_wdata;
    end
  end

  assign bus.key_ready_o = r_key_ready;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err_o;
  assign bus.reg_valid_o = r_valid;
  assign bus.reg_write_o = r_write;
  assign bus.reg_addr_o  = r_addr;
  assign bus.reg_wdata_o = r_wdata;
  assign bus.reg_wstrb_o = {(DATA_WIDTH/8){1'b1}};

endmodule

// File: tb/tb_pkt_bus_master.sv
// Directed self-checking bench for pkt_bus_master (default and read-back builds).
module tb_pkt_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pkt_bus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  pkt_bus_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // {key_ready, done, err, valid, write, addr, wdata}
  logic [68:0] obs;
  assign obs = {bus.key_ready_o, bus.done_o, bus.err_o, bus.reg_valid_o,
                bus.reg_write_o, bus.reg_addr_o, bus.reg_wdata_o};

  localparam logic [68:0] OBS_IDLE = {3'b100, 2'b00, 32'h0, 32'h0};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_clean(input string tag, input logic [31:0] idx);
    logic [68:0] exp_q[$];
    exp_q.push_back({3'b000, 2'b11, 32'h4, idx});
    exp_q.push_back({3'b000, 2'b11, 32'h0, 32'h1});
`ifdef PKT_BUS_MASTER_READBACK_EN
    exp_q.push_back({3'b000, 2'b10, 32'h0, 32'h0});
`endif
    exp_q.push_back({3'b000, 2'b11, 32'h0, 32'h0});
    exp_q.push_back({3'b010, 2'b00, 32'h0, 32'h0});
    exp_q.push_back(OBS_IDLE);
    bus.reg_ready_i = 1'b1;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = idx;
    tick();
    bus.key_valid_i = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s step %0d: got %h expected %h", tag, i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, OBS_IDLE);
    end
    tick();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, OBS_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    run_clean("nominal", 32'h0000_0007);
  endtask

  task automatic test_wait;
    logic [68:0] exp_v;
    bus.reg_ready_i = 1'b0;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = 32'hA5A5_0003;
    tick();
    bus.key_index_i = 32'hFFFF_FFFF;
    exp_v = {3'b000, 2'b11, 32'h4, 32'hA5A5_0003};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL wait_hold cycle %0d: got %h expected %h", i, obs, exp_v);
      end
      if (i == 3) bus.reg_ready_i = 1'b1;
      tick();
    end
    bus.key_valid_i = 1'b0;
    exp_v = {3'b000, 2'b11, 32'h0, 32'h1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wait_wr_req: got %h expected %h", obs, exp_v);
    end
`ifdef PKT_BUS_MASTER_READBACK_EN
    tick();
`endif
    tick();
    tick();
    exp_v = {3'b010, 2'b00, 32'h0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL wait_done: got %h expected %h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_bus_error;
    logic [68:0] exp_v;
    bus.reg_ready_i = 1'b1;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = 32'h0000_0003;
    tick();
    bus.key_valid_i = 1'b0;
    tick();
    exp_v = {3'b000, 2'b11, 32'h0, 32'h1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL buserr_wr_req: got %h expected %h", obs, exp_v);
    end
    bus.reg_error_i = 1'b1;
    tick();
    bus.reg_error_i = 1'b0;
    exp_v = {3'b011, 2'b00, 32'h0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL buserr_done: got %h expected %h", obs, exp_v);
    end
    tick();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL buserr_idle: got %h expected %h", obs, OBS_IDLE);
    end
  endtask

  task automatic test_timeout;
    int n;
    logic [68:0] exp_v;
    bus.reg_ready_i = 1'b0;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = 32'h0000_0005;
    tick();
    bus.key_valid_i = 1'b0;
    n = 0;
    while (bus.reg_valid_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL timeout_len: got %0d valid cycles expected 16", n);
    end
    exp_v = {3'b011, 2'b00, 32'h0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL timeout_done: got %h expected %h", obs, exp_v);
    end
    tick();
    bus.reg_ready_i = 1'b1;
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL timeout_idle: got %h expected %h", obs, OBS_IDLE);
    end
  endtask

  task automatic test_reset_mid;
    logic [68:0] exp_v;
    bus.reg_ready_i = 1'b1;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = 32'h0000_0009;
    tick();
    bus.key_valid_i = 1'b0;
    tick();
    exp_v = {3'b000, 2'b11, 32'h0, 32'h1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rstmid_wr_req: got %h expected %h", obs, exp_v);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL rstmid_async: got %h expected %h", obs, OBS_IDLE);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== OBS_IDLE) begin
      errors++;
      $display("FAIL rstmid_no_reissue: got %h expected %h", obs, OBS_IDLE);
    end
    run_clean("after_reset", 32'h0000_0011);
  endtask

`ifdef PKT_BUS_MASTER_READBACK_EN
  task automatic test_readback;
    logic [68:0] exp_v;
    bus.reg_ready_i = 1'b1;
    bus.reg_rdata_i = 32'h0;
    bus.key_valid_i = 1'b1;
    bus.key_index_i = 32'h0000_0002;
    tick();
    bus.key_valid_i = 1'b0;
    tick();
    tick();
    exp_v = {3'b000, 2'b10, 32'h0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rb_read: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {3'b011, 2'b00, 32'h0, 32'h0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rb_bad_done: got %h expected %h", obs, exp_v);
    end
    tick();
    bus.reg_rdata_i = 32'h1;
    run_clean("rb_ok", 32'h0000_0003);
  endtask
`endif

  initial begin
    bus.key_valid_i = 1'b0;
    bus.key_index_i = 32'h0;
    bus.reg_rdata_i = 32'h1;
    bus.reg_ready_i = 1'b0;
    bus.reg_error_i = 1'b0;
    test_reset();
    test_nominal();
    test_wait();
    test_bus_error();
    test_nominal();
    test_timeout();
    test_reset_mid();
`ifdef PKT_BUS_MASTER_READBACK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pkt_bus_master.md
PKT_BUS_MASTER -- requirements
Module: pkt_bus_master

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning register-bus address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning register-bus data width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0, meaning base address of the PKT register window.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles to wait for bus ready.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have ports key_valid_i (input, 1), key_ready_o (output, 1) and key_index_i (input, 32), forming the client request handshake.
REQ-008 The block SHALL have ports done_o (output, 1) and err_o (output, 1): a one-cycle completion pulse and its error qualifier.
REQ-009 The block SHALL have ports reg_addr_o (output, ADDR_WIDTH), reg_write_o (output, 1), reg_wdata_o (output, DATA_WIDTH), reg_wstrb_o (output, DATA_WIDTH/8) and reg_valid_o (output, 1): the register-bus initiator request.
REQ-010 The block SHALL have ports reg_rdata_i (input, DATA_WIDTH), reg_ready_i (input, 1) and reg_error_i (input, 1): the register-bus initiator response.

Function
REQ-011 The FSM states SHALL be IDLE, WR_IDX, WR_REQ, RD_CHK, WR_CLR and DONE.
REQ-012 key_ready_o SHALL be 1 only in IDLE; a transfer SHALL occur when key_valid_i && key_ready_o, latching key_index_i and moving IDLE->WR_IDX.
REQ-013 WR_IDX SHALL drive a write of the latched index to address BASE_ADDR+0x4.
REQ-014 WR_REQ SHALL drive a write of 32'h1 to address BASE_ADDR+0x0.
REQ-015 WR_CLR SHALL drive a write of 32'h0 to address BASE_ADDR+0x0, then go to DONE.
REQ-016 In every bus state, reg_valid_o SHALL be 1; addr, write and wdata SHALL stay stable until the beat completes; reg_wstrb_o SHALL be all ones.
REQ-017 A beat SHALL complete in the cycle where reg_valid_o && reg_ready_i; the next state SHALL be entered in the following cycle, with no idle cycle between beats.
REQ-018 A ready already high in the first cycle of a state SHALL complete that beat in one cycle (zero wait).
REQ-019 If reg_error_i is set on a completing beat, the block SHALL set a sticky error flag and go directly to DONE, skipping all remaining beats.
REQ-020 A wait counter SHALL clear on each state entry and increment each cycle valid is high without ready.
REQ-021 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL drop reg_valid_o, set the error flag and go to DONE.
REQ-022 DONE SHALL last exactly one cycle with done_o=1 and err_o equal to the error flag, then return to IDLE with the flag cleared.
REQ-023 done_o and err_o SHALL be 0 in all states other than DONE.
REQ-024 Outside the bus states, reg_valid_o SHALL be 0 and reg_write_o, reg_addr_o and reg_wdata_o SHALL be 0.
REQ-025 key_valid_i SHALL be ignored in all states other than IDLE.

Reset
REQ-026 Asserting rst_i SHALL immediately, including mid-transaction, force IDLE.
REQ-027 On reset, reg_valid_o, done_o and err_o SHALL be 0, key_ready_o SHALL be 1, and the latched index, error flag and wait counter SHALL be 0.
REQ-028 A beat interrupted by reset SHALL be abandoned and SHALL NOT be reissued.

Configuration
REQ-029 With PKT_BUS_MASTER_READBACK_EN defined, WR_REQ SHALL go to RD_CHK, which reads BASE_ADDR+0x0 (write=0).
REQ-030 In RD_CHK, reg_rdata_i[0]!=1 on the completing beat SHALL set the error flag and go to DONE; otherwise the block SHALL go to WR_CLR.
REQ-031 Without PKT_BUS_MASTER_READBACK_EN, RD_CHK SHALL not exist and WR_REQ SHALL go directly to WR_CLR.

Structure
REQ-032 Package pkt_bus_pkg SHALL hold the state enum and the offset constants PKT_OFF_REQ=0x0 and PKT_OFF_KEYIDX=0x4.
REQ-033 The wait counter with its timeout compare SHALL be a sub-module, pkt_bus_timeout, with inputs clear and count and output expired.

Verification
REQ-034 Ready tied 1, key 0x0000_0007 -> beats (0x4,0x7), (0x0,0x1), (0x0,0x0) on consecutive cycles, then done_o=1 and err_o=0.
REQ-035 Ready low 3 cycles on the first beat -> valid, addr and wdata held constant for 4 cycles, and the sequence completes with err_o=0.
REQ-036 reg_error_i=1 on the WR_REQ beat -> no WR_CLR beat, then done_o=1 and err_o=1 in the next cycle.
REQ-037 Ready held 0 with TIMEOUT_CYCLES=16 -> valid drops after 16 waiting cycles, then done_o=1 and err_o=1.
REQ-038 rst_i pulsed during WR_REQ -> reg_valid_o=0 and key_ready_o=1 asynchronously, and a new key then runs a full clean sequence.
REQ-039 With READBACK_EN and reg_rdata_i=0 on the read beat -> err_o=1 with no clear beat; with reg_rdata_i=1 -> a clear beat and err_o=0.
